// File: rtl/flash_image_loader.sv
// Flash image loader: buffers an AXI-Stream byte image one page at a time
// and sequences erase/write commands to the SPI flash engine. The engine has
// no status polling, so program and erase wait times are timed by counters.
//
// Handshakes: a byte moves on s_axis when s_axis_tvalid && s_axis_tready at
// a rising clock edge, and on fl_* when fl_tvalid && fl_tready. A valid byte
// is held unchanged until it is taken. Neither ready ever waits on its own
// valid.
module flash_image_loader #(
  parameter int PAGE_BYTES     = 256,
  parameter int TAIL_CYC       = 32,
  parameter int PROG_WAIT_CYC  = 125000,
  parameter int ERASE_WAIT_CYC = 20000000,
  parameter int GAP_CYC        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        fl_write_strobe,
  output logic        fl_erase_strobe,
  output logic [23:0] fl_start_addr,
  output logic [7:0]  fl_tdata,
  output logic        fl_tvalid,
  input  logic        fl_tready,
  input  logic        fl_finished,
  output logic        busy,
  output logic        done,
  output logic [15:0] pages_written,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(PAGE_BYTES) + 1;
  localparam int AW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;

  // Wait states also have to cover the minimum strobe-low gap, so each one
  // runs for the longer of its own wait and the gap.
  localparam logic [31:0] ERASE_LIM =
    32'(((ERASE_WAIT_CYC > GAP_CYC) ? ERASE_WAIT_CYC : GAP_CYC) - 1);
  localparam logic [31:0] PROG_LIM =
    32'(((PROG_WAIT_CYC > GAP_CYC) ? PROG_WAIT_CYC : GAP_CYC) - 1);
  localparam logic [31:0] TAIL_LIM =
    32'(((TAIL_CYC > 1) ? TAIL_CYC : 1) - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FILL       = 3'd1,
    S_ERASE      = 3'd2,
    S_ERASE_WAIT = 3'd3,
    S_WRITE      = 3'd4,
    S_TAIL       = 3'd5,
    S_PROG_WAIT  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  page_mem [PAGE_BYTES];
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd;
  logic        last;
  logic        need_erase;
  logic [23:0] addr;
  logic [23:0] addr_next;
  logic [31:0] wcnt;

  logic in_hs;
  logic out_hs;
  logic fill_end;
  logic write_end;
  logic erase_wait_end;
  logic tail_end;
  logic prog_end;

  assign in_hs          = (state == S_FILL) && s_axis_tvalid && s_axis_tready;
  assign out_hs         = (state == S_WRITE) && fl_tready;
  assign fill_end       = in_hs && (s_axis_tlast || (cnt == CW'(PAGE_BYTES - 1)));
  assign write_end      = out_hs && (rd == cnt - CW'(1));
  assign erase_wait_end = (state == S_ERASE_WAIT) && (wcnt == ERASE_LIM);
  assign tail_end       = (state == S_TAIL) && (wcnt == TAIL_LIM);
  assign prog_end       = (state == S_PROG_WAIT) && (wcnt == PROG_LIM);
  assign addr_next      = addr + 24'(PAGE_BYTES);

  // Outputs decoded from state so an async reset drops them immediately.
  assign s_axis_tready   = (state == S_FILL) && (cnt < CW'(PAGE_BYTES));
  assign fl_erase_strobe = (state == S_ERASE);
  assign fl_write_strobe = (state == S_WRITE) || (state == S_TAIL);
  assign fl_start_addr   = (fl_erase_strobe || fl_write_strobe) ? addr : 24'h000000;
  assign fl_tvalid       = (state == S_WRITE);
  assign fl_tdata        = (state == S_WRITE) ? page_mem[rd[AW-1:0]] : 8'h00;
  assign busy            = (state != S_IDLE);
  assign state_dbg       = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start) state_next = S_FILL;
      S_FILL:       if (fill_end) state_next = need_erase ? S_ERASE : S_WRITE;
      S_ERASE:      if (fl_finished) state_next = S_ERASE_WAIT;
      S_ERASE_WAIT: if (erase_wait_end) state_next = S_WRITE;
      S_WRITE:      if (write_end) state_next = S_TAIL;
      S_TAIL:       if (tail_end) state_next = S_PROG_WAIT;
      S_PROG_WAIT:  if (prog_end) state_next = last ? S_IDLE : S_FILL;
      default:      state_next = S_IDLE;
    endcase
  end

  // Page buffer; contents need no reset because cnt bounds what is read.
  always_ff @(posedge clk) begin
    if (in_hs) page_mem[cnt[AW-1:0]] <= s_axis_tdata;
  end

  // Datapath: fill/read pointers, flash address, wait counter, progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      rd            <= '0;
      last          <= 1'b0;
      need_erase    <= 1'b0;
      addr          <= 24'h000000;
      wcnt          <= 32'd0;
      pages_written <= 16'd0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_next != state) wcnt <= 32'd0;
      else if (state == S_ERASE_WAIT || state == S_TAIL || state == S_PROG_WAIT)
        wcnt <= wcnt + 32'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr          <= base_addr & ~24'(PAGE_BYTES - 1);
            need_erase    <= 1'b1;
            cnt           <= '0;
            rd            <= '0;
            last          <= 1'b0;
            pages_written <= 16'd0;
          end
        end
        S_FILL: begin
          if (in_hs) begin
            cnt <= cnt + CW'(1);
            if (s_axis_tlast) last <= 1'b1;
          end
        end
        S_ERASE_WAIT: begin
          if (erase_wait_end) need_erase <= 1'b0;
        end
        S_WRITE: begin
          if (out_hs) rd <= rd + CW'(1);
        end
        S_PROG_WAIT: begin
          if (prog_end) begin
            pages_written <= pages_written + 16'd1;
            addr          <= addr_next;
            cnt           <= '0;
            rd            <= '0;
            need_erase    <= (addr_next[14:0] == 15'd0);
            done          <= last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
